traffic_phase_scheduler: RTL and testbench

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

---
 rtl/traffic_phase_scheduler.sv | 173 +++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Four-approach traffic phase scheduler: ALLRED -> GREEN -> YELLOW rotation with
// call latching, presence-based green extension and emergency preemption.
module traffic_phase_scheduler #(
    parameter int unsigned GREEN_MIN = 8,
    parameter int unsigned GREEN_MAX = 20,
    parameter int unsigned YELLOW_T  = 4,
    parameter int unsigned ALLRED_T  = 2,
    parameter int unsigned TW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    req,
    input  logic [3:0]    ext,
    input  logic          emg,
    input  logic [1:0]    emg_dir,
    output logic [3:0]    r,
    output logic [3:0]    y,
    output logic [3:0]    g,
    output logic [3:0]    gnt,
    output logic [1:0]    phase,
    output logic [TW-1:0] c
);

    typedef enum logic [1:0] {
        StAllRed = 2'b00,
        StGreen  = 2'b01,
        StYellow = 2'b10
    } state_e;

    // Last timer value of each timed interval (exit happens at the end of that cycle)
    localparam logic [TW-1:0] AllRedLast   = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] GreenMinLast = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GreenMaxLast = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] YellowLast   = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] TimerMax     = '1;

    state_e        state_q, state_d;
    logic [1:0]    cur_q, cur_d;
    logic [3:0]    pend_q, pend_d;
    logic [TW-1:0] c_q, c_d;

    logic [3:0]    cur_onehot;
    logic [3:0]    green_mask;
    logic [3:0]    pend_view;
    logic          other_pend;
    logic          pick_valid;
    logic [1:0]    pick_idx;
    logic          enter_green;
    logic [3:0]    enter_mask;

    assign cur_onehot = 4'b0001 << cur_q;
    // Calls from the approach currently showing green are ignored
    assign green_mask = (state_q == StGreen) ? cur_onehot : 4'b0000;
    // Latched calls plus calls arriving this cycle, so a call in the ALLRED exit
    // cycle is served on the very next edge
    assign pend_view  = pend_q | (req & ~green_mask);
    assign other_pend = |(pend_q & ~cur_onehot);

    // Round-robin pick: first pending approach after cur, cur itself last
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = cur_q;
        for (int k = 1; k <= 4; k++) begin
            if (!pick_valid && pend_view[cur_q + 2'(k)]) begin
                pick_valid = 1'b1;
                pick_idx   = cur_q + 2'(k);
            end
        end
    end

    // State, served approach, pending calls and phase timer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StAllRed;
            cur_q   <= 2'd0;
            pend_q  <= 4'b0000;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            c_q     <= c_d;
        end
    end

    // Next-state and next served approach
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        case (state_q)
            StAllRed: begin
                if (c_q >= AllRedLast) begin
                    if (emg) begin
                        state_d = StGreen;
                        cur_d   = emg_dir;
                    end else if (pick_valid) begin
                        state_d = StGreen;
                        cur_d   = pick_idx;
                    end
                end
            end
            StGreen: begin
                if (emg) begin
                    // Preempt: leave at once unless this approach is the preempt target
                    if (emg_dir != cur_q) begin
                        state_d = StYellow;
                    end
                end else if ((c_q >= GreenMinLast) && other_pend &&
                             (!ext[cur_q] || (c_q >= GreenMaxLast))) begin
                    state_d = StYellow;
                end
            end
            StYellow: begin
                if (c_q >= YellowLast) begin
                    state_d = StAllRed;
                end
            end
            default: begin
                state_d = StAllRed;
            end
        endcase
    end

    // Timer restarts on every state change and saturates at its maximum
    always_comb begin
        if (state_d != state_q) begin
            c_d = '0;
        end else if (c_q == TimerMax) begin
            c_d = c_q;
        end else begin
            c_d = c_q + TW'(1);
        end
    end

    // Pending latch: set by calls, cleared when the approach enters green (clear wins)
    always_comb begin
        enter_green = (state_d == StGreen) && (state_q != StGreen);
        enter_mask  = enter_green ? (4'b0001 << cur_d) : 4'b0000;
        pend_d      = pend_view & ~enter_mask;
    end

    // Lamp, grant and status decode from registered state only
    always_comb begin
        r     = 4'b1111;
        y     = 4'b0000;
        g     = 4'b0000;
        gnt   = 4'b0000;
        phase = state_q;
        c     = c_q;
        case (state_q)
            StGreen: begin
                g = cur_onehot;
                r = ~cur_onehot;
                // Timer is zero only in the first cycle of a state
                if (c_q == '0) begin
                    gnt = cur_onehot;
                end
            end
            StYellow: begin
                y = cur_onehot;
                r = ~cur_onehot;
            end
            default: begin
                r = 4'b1111;
            end
        endcase
    end

    // Exactly one lamp lit per approach
    lamp_onehot_a : assert property (@(posedge clk) disable iff (!reset)
        ((r | y | g) == 4'b1111) && (((r & y) | (r & g) | (y & g)) == 4'b0000));

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with default parameters.
module tb_traffic_phase_scheduler;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] ext;
    logic       emg;
    logic [1:0] emg_dir;
    logic [3:0] r;
    logic [3:0] y;
    logic [3:0] g;
    logic [3:0] gnt;
    logic [1:0] phase;
    logic [7:0] c;

    int n_tests;
    int n_fail;

    traffic_phase_scheduler dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .ext     (ext),
        .emg     (emg),
        .emg_dir (emg_dir),
        .r       (r),
        .y       (y),
        .g       (g),
        .gnt     (gnt),
        .phase   (phase),
        .c       (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Checks n consecutive cycles of one phase; packed as {phase, r, y, g, gnt, c}.
    // Any req pulse applied before the call is dropped after the first cycle.
    task automatic run_phase(input string tag, input int n, input int c0, input logic [1:0] ph,
                             input logic [3:0] er, input logic [3:0] ey, input logic [3:0] eg);
        logic [3:0] egnt;
        for (int k = 0; k < n; k++) begin
            egnt = (ph == 2'b01 && (c0 + k) == 0) ? eg : 4'b0000;
            check(tag, {6'd0, phase, r, y, g, gnt, c}, {6'd0, ph, er, ey, eg, egnt, 8'(c0 + k)});
            @(negedge clk);
            if (k == 0) req = 4'b0000;
        end
    endtask

    // Asynchronous reset between clock edges; outputs must drop without a clock edge
    task automatic async_reset_check(input string tag);
        #2 reset = 1'b0;
        #1 check(tag, {6'd0, phase, r, y, g, gnt, c}, {6'd0, 2'b00, 4'b1111, 12'd0, 8'd0});
        @(negedge clk);
        reset = 1'b1;
    endtask

    // From a fresh reset: call approach 0 and land on its first green cycle
    task automatic go_green0();
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        req     = 4'b0000;
        ext     = 4'b0000;
        emg     = 1'b0;
        emg_dir = 2'd0;

        repeat (3) @(negedge clk);
        check("rst_hold", {6'd0, phase, r, y, g, gnt, c}, {6'd0, 2'b00, 4'b1111, 12'd0, 8'd0});
        reset = 1'b1;

        // Idle: no calls, ALLRED held and timer counting
        run_phase("idle", 50, 0, 2'b00, 4'b1111, 4'b0000, 4'b0000);

        // Single call on approach 2 while ALLRED has expired
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        run_phase("g2_rest", 100, 0, 2'b01, 4'b1011, 4'b0000, 4'b0100);
        async_reset_check("rst_green");

        // Rotation 0 -> 1 -> 3 with no extension
        go_green0();
        req = 4'b1010;
        run_phase("rot_g0", 8, 0, 2'b01, 4'b1110, 4'b0000, 4'b0001);
        run_phase("rot_y0", 4, 0, 2'b10, 4'b1110, 4'b0001, 4'b0000);
        run_phase("rot_ar0", 2, 0, 2'b00, 4'b1111, 4'b0000, 4'b0000);
        run_phase("rot_g1", 8, 0, 2'b01, 4'b1101, 4'b0000, 4'b0010);
        run_phase("rot_y1", 4, 0, 2'b10, 4'b1101, 4'b0010, 4'b0000);
        run_phase("rot_ar1", 2, 0, 2'b00, 4'b1111, 4'b0000, 4'b0000);
        run_phase("rot_g3", 12, 0, 2'b01, 4'b0111, 4'b0000, 4'b1000);
        async_reset_check("rst_g3");

        // Extension held: green capped at GREEN_MAX
        go_green0();
        ext = 4'b0001;
        req = 4'b0010;
        run_phase("ext_max_g", 20, 0, 2'b01, 4'b1110, 4'b0000, 4'b0001);
        run_phase("ext_max_y", 4, 0, 2'b10, 4'b1110, 4'b0001, 4'b0000);
        ext = 4'b0000;
        async_reset_check("rst_allred");

        // Extension dropped at c=12: yellow right after that cycle
        go_green0();
        ext = 4'b0001;
        req = 4'b0010;
        run_phase("ext_drop_g", 12, 0, 2'b01, 4'b1110, 4'b0000, 4'b0001);
        ext = 4'b0000;
        run_phase("ext_drop_c12", 1, 12, 2'b01, 4'b1110, 4'b0000, 4'b0001);
        run_phase("ext_drop_y", 4, 0, 2'b10, 4'b1110, 4'b0001, 4'b0000);
        async_reset_check("rst_ext");

        // Emergency preempt toward approach 2 from green 0 at c=3
        go_green0();
        run_phase("emg_pre", 3, 0, 2'b01, 4'b1110, 4'b0000, 4'b0001);
        emg     = 1'b1;
        emg_dir = 2'd2;
        req     = 4'b0010;
        run_phase("emg_c3", 1, 3, 2'b01, 4'b1110, 4'b0000, 4'b0001);
        run_phase("emg_y", 4, 0, 2'b10, 4'b1110, 4'b0001, 4'b0000);
        run_phase("emg_ar", 2, 0, 2'b00, 4'b1111, 4'b0000, 4'b0000);
        run_phase("emg_hold", 40, 0, 2'b01, 4'b1011, 4'b0000, 4'b0100);
        emg = 1'b0;
        run_phase("emg_rel", 1, 40, 2'b01, 4'b1011, 4'b0000, 4'b0100);
        run_phase("emg_rel_y", 2, 0, 2'b10, 4'b1011, 4'b0100, 4'b0000);
        async_reset_check("rst_yellow");

        // Call on 2 held across its green entry must not be served twice
        req = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        req = 4'b0110;
        run_phase("once_g2", 8, 0, 2'b01, 4'b1011, 4'b0000, 4'b0100);
        run_phase("once_y2", 4, 0, 2'b10, 4'b1011, 4'b0100, 4'b0000);
        run_phase("once_ar", 2, 0, 2'b00, 4'b1111, 4'b0000, 4'b0000);
        run_phase("once_g1", 12, 0, 2'b01, 4'b1101, 4'b0000, 4'b0010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
